timing_peak_detect: RTL and testbench

TIMING_PEAK_DETECT -- requirements
Module: timing_peak_detect

---
 rtl/timing_peak_detect.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_timing_peak_detect.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/timing_peak_detect.sv
// timing_peak_detect: timing-synchronisation peak detector.
// Squares the moving correlation and energy sums, flags samples whose
// normalised metric |P|^2 / E^2 exceeds THR_NUM / 2^THR_SHIFT, tracks the
// strongest exceeding sample and confirms it after HOLD_LEN valid samples
// without improvement, then blanks for BLANK_LEN valid samples.
// Optional build macro: TIMING_PEAK_CFO_OUT_EN adds peak_corr_real and
// peak_corr_imag, the correlation value captured at the detected peak.
module timing_peak_detect #(
  parameter int          WL_IN     = 24,
  parameter int unsigned THR_NUM   = 3,
  parameter int          THR_SHIFT = 2,
  parameter int          HOLD_LEN  = 16,
  parameter int          BLANK_LEN = 64,
  parameter int          IDX_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic signed [WL_IN-1:0]   sum_corr_real,
  input  logic signed [WL_IN-1:0]   sum_corr_imag,
  input  logic signed [WL_IN-1:0]   sum_energy,
  output logic                      peak_valid,
  output logic [IDX_W-1:0]          peak_index,
  output logic [2*WL_IN-1:0]        peak_metric,
  output logic                      busy
`ifdef TIMING_PEAK_CFO_OUT_EN
  ,
  output logic signed [WL_IN-1:0]   peak_corr_real,
  output logic signed [WL_IN-1:0]   peak_corr_imag
`endif
);

  localparam int M_W     = 2 * WL_IN;
  // Wide enough for num << THR_SHIFT and THR_NUM * den without any loss
  localparam int CMP_W   = M_W + 32 + THR_SHIFT;
  localparam int HOLD_W  = (HOLD_LEN  < 1) ? 1 : $clog2(HOLD_LEN + 1);
  localparam int BLANK_W = (BLANK_LEN < 1) ? 1 : $clog2(BLANK_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  // Squared magnitude of a signed sum; the result always fits M_W bits.
  function automatic logic [M_W-1:0] sq(input logic signed [WL_IN-1:0] x);
    logic signed [M_W-1:0] xe;
    xe = M_W'(x);
    return $unsigned(xe * xe);
  endfunction

  // Energy is physically non-negative; a negative sum is treated as zero.
  function automatic logic signed [WL_IN-1:0] clamp_nonneg(input logic signed [WL_IN-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  // Threshold test num / den > THR_NUM / 2^THR_SHIFT, cross-multiplied.
  function automatic logic thr_exceed(input logic [M_W-1:0] num, input logic [M_W-1:0] den);
    logic [CMP_W-1:0] lhs;
    logic [CMP_W-1:0] rhs;
    lhs = CMP_W'(num) << THR_SHIFT;
    rhs = CMP_W'(den) * CMP_W'(THR_NUM);
    return (den != '0) && (lhs > rhs);
  endfunction

  // Control state
  logic [IDX_W-1:0]   idx_cnt_q, idx_cnt_d;
  logic               vld_p1_q, vld_p1_d;
  logic               vld_p2_q, vld_p2_d;
  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;

  // Pipeline / candidate data
  logic [M_W-1:0]     num_p1_q, num_p1_d;
  logic [M_W-1:0]     den_p1_q, den_p1_d;
  logic [IDX_W-1:0]   idx_p1_q, idx_p1_d;
  logic               exceed_p2_q, exceed_p2_d;
  logic [M_W-1:0]     num_p2_q, num_p2_d;
  logic [IDX_W-1:0]   idx_p2_q, idx_p2_d;
  logic [M_W-1:0]     max_q, max_d;
  logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;

  // Registered outputs
  logic               peak_valid_q, peak_valid_d;
  logic [IDX_W-1:0]   peak_index_q, peak_index_d;
  logic [M_W-1:0]     peak_metric_q, peak_metric_d;
  logic               busy_q, busy_d;

  // Decode helpers
  logic               upd;
  logic               detect;
  logic [HOLD_W-1:0]  hold_inc;
  logic [BLANK_W-1:0] blank_inc;
  logic               hold_hit;
  logic               blank_done;

`ifdef TIMING_PEAK_CFO_OUT_EN
  logic signed [WL_IN-1:0] corr_re_p1_q, corr_re_p1_d;
  logic signed [WL_IN-1:0] corr_im_p1_q, corr_im_p1_d;
  logic signed [WL_IN-1:0] corr_re_p2_q, corr_re_p2_d;
  logic signed [WL_IN-1:0] corr_im_p2_q, corr_im_p2_d;
  logic signed [WL_IN-1:0] cand_re_q, cand_re_d;
  logic signed [WL_IN-1:0] cand_im_q, cand_im_d;
  logic signed [WL_IN-1:0] peak_corr_real_q, peak_corr_real_d;
  logic signed [WL_IN-1:0] peak_corr_imag_q, peak_corr_imag_d;
`endif

  // Input acceptance: index counter and valid bits; clear discards the sample
  always_comb begin
    idx_cnt_d = idx_cnt_q;
    vld_p1_d  = in_valid && !clear;
    vld_p2_d  = vld_p1_q && !clear;
    if (clear) begin
      idx_cnt_d = '0;
    end else if (in_valid) begin
      idx_cnt_d = idx_cnt_q + IDX_W'(1);
    end
  end

  // Stage 1 boundary: squared correlation magnitude and squared clamped energy
  always_comb begin
    num_p1_d = sq(sum_corr_real) + sq(sum_corr_imag);
    den_p1_d = sq(clamp_nonneg(sum_energy));
    idx_p1_d = idx_cnt_q;
`ifdef TIMING_PEAK_CFO_OUT_EN
    corr_re_p1_d = sum_corr_real;
    corr_im_p1_d = sum_corr_imag;
`endif
  end

  // Stage 2 boundary: threshold decision travels with the metric and index
  always_comb begin
    exceed_p2_d = thr_exceed(num_p1_q, den_p1_q);
    num_p2_d    = num_p1_q;
    idx_p2_d    = idx_p1_q;
`ifdef TIMING_PEAK_CFO_OUT_EN
    corr_re_p2_d = corr_re_p1_q;
    corr_im_p2_d = corr_im_p1_q;
`endif
  end

  // Decode of the stage-2 sample against the current candidate and counters
  always_comb begin
    hold_inc   = hold_cnt_q + HOLD_W'(1);
    blank_inc  = blank_cnt_q + BLANK_W'(1);
    hold_hit   = (hold_inc == HOLD_W'(HOLD_LEN));
    blank_done = (blank_inc >= BLANK_W'(BLANK_LEN));
    upd        = vld_p2_q && exceed_p2_q && (num_p2_q > max_q);
    detect     = !clear && vld_p2_q && (state_q == ST_SEARCH) && !upd && hold_hit;
  end

  // FSM next state, counters and candidate tracking
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    blank_cnt_d = blank_cnt_q;
    max_d       = max_q;
    cand_idx_d  = cand_idx_q;
`ifdef TIMING_PEAK_CFO_OUT_EN
    cand_re_d   = cand_re_q;
    cand_im_d   = cand_im_q;
`endif
    if (clear) begin
      state_d     = ST_IDLE;
      hold_cnt_d  = '0;
      blank_cnt_d = '0;
    end else if (vld_p2_q) begin
      case (state_q)
        ST_IDLE: begin
          if (exceed_p2_q) begin
            max_d      = num_p2_q;
            cand_idx_d = idx_p2_q;
`ifdef TIMING_PEAK_CFO_OUT_EN
            cand_re_d  = corr_re_p2_q;
            cand_im_d  = corr_im_p2_q;
`endif
            hold_cnt_d = '0;
            state_d    = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (upd) begin
            max_d      = num_p2_q;
            cand_idx_d = idx_p2_q;
`ifdef TIMING_PEAK_CFO_OUT_EN
            cand_re_d  = corr_re_p2_q;
            cand_im_d  = corr_im_p2_q;
`endif
            hold_cnt_d = '0;
          end else if (hold_hit) begin
            hold_cnt_d  = '0;
            blank_cnt_d = '0;
            state_d     = (BLANK_LEN == 0) ? ST_IDLE : ST_BLANK;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
        ST_BLANK: begin
          if (blank_done) begin
            blank_cnt_d = '0;
            state_d     = ST_IDLE;
          end else begin
            blank_cnt_d = blank_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM outputs: detection pulse, held peak report and busy flag
  always_comb begin
    peak_valid_d  = detect;
    peak_index_d  = detect ? cand_idx_q : peak_index_q;
    peak_metric_d = detect ? max_q : peak_metric_q;
    busy_d        = (state_d != ST_IDLE);
`ifdef TIMING_PEAK_CFO_OUT_EN
    peak_corr_real_d = detect ? cand_re_q : peak_corr_real_q;
    peak_corr_imag_d = detect ? cand_im_q : peak_corr_imag_q;
`endif
  end

  // Pipeline control registers: index counter and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_cnt_q <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
    end else begin
      idx_cnt_q <= idx_cnt_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  // FSM state register with hold and blank counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_valid_q  <= 1'b0;
      peak_index_q  <= '0;
      peak_metric_q <= '0;
      busy_q        <= 1'b0;
`ifdef TIMING_PEAK_CFO_OUT_EN
      peak_corr_real_q <= '0;
      peak_corr_imag_q <= '0;
`endif
    end else begin
      peak_valid_q  <= peak_valid_d;
      peak_index_q  <= peak_index_d;
      peak_metric_q <= peak_metric_d;
      busy_q        <= busy_d;
`ifdef TIMING_PEAK_CFO_OUT_EN
      peak_corr_real_q <= peak_corr_real_d;
      peak_corr_imag_q <= peak_corr_imag_d;
`endif
    end
  end

  // Datapath registers; qualified by the valid bits and candidate state, so no reset
  always_ff @(posedge clk) begin
    num_p1_q    <= num_p1_d;
    den_p1_q    <= den_p1_d;
    idx_p1_q    <= idx_p1_d;
    exceed_p2_q <= exceed_p2_d;
    num_p2_q    <= num_p2_d;
    idx_p2_q    <= idx_p2_d;
    max_q       <= max_d;
    cand_idx_q  <= cand_idx_d;
`ifdef TIMING_PEAK_CFO_OUT_EN
    corr_re_p1_q <= corr_re_p1_d;
    corr_im_p1_q <= corr_im_p1_d;
    corr_re_p2_q <= corr_re_p2_d;
    corr_im_p2_q <= corr_im_p2_d;
    cand_re_q    <= cand_re_d;
    cand_im_q    <= cand_im_d;
`endif
  end

  assign peak_valid  = peak_valid_q;
  assign peak_index  = peak_index_q;
  assign peak_metric = peak_metric_q;
  assign busy        = busy_q;
`ifdef TIMING_PEAK_CFO_OUT_EN
  assign peak_corr_real = peak_corr_real_q;
  assign peak_corr_imag = peak_corr_imag_q;
`endif

endmodule

// File: tb/tb_timing_peak_detect.sv
// Directed bench for timing_peak_detect (HOLD_LEN=4, BLANK_LEN=8, IDX_W=4).
module tb_timing_peak_detect;

  localparam int WL = 24;
  localparam int IW = 4;

  logic                 clk;
  logic                 rst;
  logic                 clear;
  logic                 in_valid;
  logic signed [WL-1:0] sum_corr_real;
  logic signed [WL-1:0] sum_corr_imag;
  logic signed [WL-1:0] sum_energy;
  logic                 peak_valid;
  logic [IW-1:0]        peak_index;
  logic [2*WL-1:0]      peak_metric;
  logic                 busy;
`ifdef TIMING_PEAK_CFO_OUT_EN
  logic signed [WL-1:0] peak_corr_real;
  logic signed [WL-1:0] peak_corr_imag;
`endif

  timing_peak_detect #(
    .WL_IN(WL), .THR_NUM(3), .THR_SHIFT(2), .HOLD_LEN(4), .BLANK_LEN(8), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .sum_corr_real(sum_corr_real), .sum_corr_imag(sum_corr_imag),
    .sum_energy(sum_energy), .peak_valid(peak_valid), .peak_index(peak_index),
    .peak_metric(peak_metric), .busy(busy)
`ifdef TIMING_PEAK_CFO_OUT_EN
    , .peak_corr_real(peak_corr_real), .peak_corr_imag(peak_corr_imag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;
  int cyc;
  int npk;
  logic busy_hi;
  int log_idx [16];
  int log_cyc [16];
  int log_re  [16];
  logic [2*WL-1:0] log_met [16];

  int pat1 [9]  = '{0, 80, 90, 95, 90, 80, 0, 0, 0};
  int tie  [8]  = '{0, 90, 95, 95, 0, 0, 0, 0};
  int rep  [12] = '{0, 80, 90, 95, 90, 80, 0, 0, 0, 0, 0, 0};
  int f_idx [3] = '{3, 0, 7};
  int f_met [3] = '{9025, 8100, 9025};
  int f_off [3] = '{10, 23, 46};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, wait for the edge, sample 1 time unit later.
  task automatic send(input logic clr, input logic v, input int re, input int im, input int e);
    clear         = clr;
    in_valid      = v;
    sum_corr_real = WL'(re);
    sum_corr_imag = WL'(im);
    sum_energy    = WL'(e);
    @(posedge clk);
    #1;
    cyc++;
    if (peak_valid) begin
      if (npk < 16) begin
        log_idx[npk] = int'(peak_index);
        log_met[npk] = peak_metric;
        log_cyc[npk] = cyc;
`ifdef TIMING_PEAK_CFO_OUT_EN
        log_re[npk]  = int'(peak_corr_real);
`else
        log_re[npk]  = 0;
`endif
      end
      npk++;
    end
    if (busy) busy_hi = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    int nb;
    int c7;
    int cyc0;
    n_run = 0; n_fail = 0; cyc = 0; npk = 0; busy_hi = 1'b0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    sum_corr_real = '0; sum_corr_imag = '0; sum_energy = '0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_peak_valid", 64'(peak_valid), 64'(0));
    chk("rst_peak_index", 64'(peak_index), 64'(0));
    chk("rst_peak_metric", 64'(peak_metric), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    // Single peak: confirm at sample 7, peak at sample 3 (95^2)
    nb = npk;
    c7 = 0;
    for (int i = 0; i < 9; i++) begin
      send(1'b0, 1'b1, pat1[i], 0, 100);
      if (i == 7) c7 = cyc;
    end
    idle(3);
    chk("single_count", 64'(npk - nb), 64'(1));
    chk("single_index", 64'(log_idx[nb]), 64'(3));
    chk("single_metric", 64'(log_met[nb]), 64'(9025));
    chk("single_latency", 64'(log_cyc[nb]), 64'(c7 + 2));
    chk("single_pulse_end", 64'(peak_valid), 64'(0));
    chk("single_index_held", 64'(peak_index), 64'(3));
    chk("single_busy_blank", 64'(busy), 64'(1));
`ifdef TIMING_PEAK_CFO_OUT_EN
    chk("single_corr_real", 64'(log_re[nb]), 64'(95));
`endif

    // Asynchronous reset mid-cycle while blanking
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(peak_valid), 64'(0));
    chk("async_rst_index", 64'(peak_index), 64'(0));
    chk("async_rst_metric", 64'(peak_metric), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    #1 rst = 1'b0;

    // Reset during SEARCH discards the candidate
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1, pat1[i], 0, 100);
    idle(1);
    chk("search_busy", 64'(busy), 64'(1));
    nb = npk;
    #3 rst = 1'b1;
    #1;
    chk("search_rst_busy", 64'(busy), 64'(0));
    #1 rst = 1'b0;
    idle(6);
    chk("search_rst_no_peak", 64'(npk - nb), 64'(0));

    // Zero energy and negative (clamped) energy never detect
    nb = npk;
    busy_hi = 1'b0;
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1, 50, 0, 0);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1, 95, 0, -100);
    idle(3);
    chk("zero_energy_no_peak", 64'(npk - nb), 64'(0));
    chk("zero_energy_busy", 64'(busy_hi), 64'(0));

    // Clear during SEARCH, with a simultaneous sample that must be dropped
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1, pat1[i], 0, 100);
    idle(1);
    chk("clear_pre_busy", 64'(busy), 64'(1));
    nb = npk;
    send(1'b1, 1'b1, 95, 0, 100);
    chk("clear_busy", 64'(busy), 64'(0));
    chk("clear_no_peak", 64'(npk - nb), 64'(0));

    // Tie after clear: earliest of equal maxima wins, indices restart at 0
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, tie[i], 0, 100);
    idle(2);
    chk("tie_count", 64'(npk - nb), 64'(1));
    chk("tie_index", 64'(log_idx[nb]), 64'(2));
    chk("tie_metric", 64'(log_met[nb]), 64'(9025));

    // Repeated pattern every 12 samples: blanking and 4-bit index wrap
    send(1'b1, 1'b0, 0, 0, 0);
    cyc0 = cyc;
    nb = npk;
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 12; p++) send(1'b0, 1'b1, rep[p], 0, 100);
    idle(3);
    chk("wrap_count", 64'(npk - nb), 64'(3));
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("wrap%0d_index", j), 64'(log_idx[nb + j]), 64'(f_idx[j]));
      chk($sformatf("wrap%0d_metric", j), 64'(log_met[nb + j]), 64'(f_met[j]));
      chk($sformatf("wrap%0d_cycle", j), 64'(log_cyc[nb + j] - cyc0), 64'(f_off[j]));
    end
`ifdef TIMING_PEAK_CFO_OUT_EN
    chk("wrap0_corr_real", 64'(log_re[nb]), 64'(95));
    chk("wrap2_corr_real", 64'(log_re[nb + 2]), 64'(95));
`endif

    // Signed complex magnitude: (-60, 70) gives 3600 + 4900
    send(1'b1, 1'b0, 0, 0, 0);
    nb = npk;
    send(1'b0, 1'b1, -60, 70, 100);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 0, 0, 100);
    idle(2);
    chk("cplx_count", 64'(npk - nb), 64'(1));
    chk("cplx_index", 64'(log_idx[nb]), 64'(0));
    chk("cplx_metric", 64'(log_met[nb]), 64'(8500));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
